// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a multicycle RV32I datapath.
// Sequences fetch/decode/exec/mem/wb with bounded memory handshakes.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        imem_ready,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic        br_taken,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_we,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        rf_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state,
  output logic        illegal,
  output logic        bus_err,
  output logic [31:0] instret
);

  localparam int CW =
    (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_NONE, C_R, C_IALU, C_LOAD, C_STORE,
    C_BR, C_JAL, C_JALR, C_LUI, C_AUIPC, C_FENCE
  } cls_t;

  state_t        cur;
  state_t        nxt;
  cls_t          cls;
  cls_t          cls_nx;
  cls_t          dec;
  logic [CW-1:0] wcnt;
  logic [CW-1:0] wcnt_nx;
  logic          ill_nx;
  logic          berr_nx;
  logic          ret;
  logic          timeout;

  assign state   = cur;
  assign timeout = (wcnt == TMO);

  always_comb begin
    dec = C_NONE;
    case (opcode)
      7'b0110011: dec = C_R;
      7'b0010011: dec = C_IALU;
      7'b0000011: dec = C_LOAD;
      7'b0100011: dec = C_STORE;
      7'b1100011: dec = C_BR;
      7'b1101111: dec = C_JAL;
      7'b1100111: dec = C_JALR;
      7'b0110111: dec = C_LUI;
      7'b0010111: dec = C_AUIPC;
      7'b0001111: dec = C_FENCE;
      default:    dec = C_NONE;
    endcase
  end

  always_comb begin
    nxt      = cur;
    cls_nx   = cls;
    wcnt_nx  = wcnt;
    ill_nx   = illegal;
    berr_nx  = bus_err;
    ret      = 1'b0;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 2'b00;
    wb_sel   = 2'b00;

    case (cur)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we = 1'b1;
          nxt   = S_DECODE;
        end else if (timeout) begin
          berr_nx = 1'b1;
          nxt     = S_HALT;
        end else begin
          wcnt_nx = wcnt + CW'(1);
        end
      end

      S_DECODE: begin
        cls_nx = dec;
        if (dec == C_NONE) begin
          ill_nx = 1'b1;
          nxt    = S_HALT;
        end else begin
          nxt = S_EXEC;
        end
      end

      S_EXEC: begin
        case (cls)
          C_LOAD, C_STORE: begin
            wcnt_nx = '0;
            nxt     = S_MEM;
          end
          C_BR: begin
            pc_we   = 1'b1;
            pc_sel  = br_taken ? 2'b01 : 2'b00;
            ret     = 1'b1;
            wcnt_nx = '0;
            nxt     = S_FETCH;
          end
          C_FENCE: begin
            pc_we   = 1'b1;
            ret     = 1'b1;
            wcnt_nx = '0;
            nxt     = S_FETCH;
          end
          C_NONE:  nxt = S_HALT;
          default: nxt = S_WB;
        endcase
      end

      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls == C_STORE);
        if (dmem_ready) begin
          if (cls == C_STORE) begin
            pc_we   = 1'b1;
            ret     = 1'b1;
            wcnt_nx = '0;
            nxt     = S_FETCH;
          end else begin
            nxt = S_WB;
          end
        end else if (timeout) begin
          berr_nx = 1'b1;
          nxt     = S_HALT;
        end else begin
          wcnt_nx = wcnt + CW'(1);
        end
      end

      S_WB: begin
        rf_we   = (rd != 5'd0);
        pc_we   = 1'b1;
        ret     = 1'b1;
        wcnt_nx = '0;
        nxt     = S_FETCH;
        case (cls)
          C_LOAD:  wb_sel = 2'b01;
          C_JAL:   wb_sel = 2'b10;
          C_JALR:  wb_sel = 2'b10;
          default: wb_sel = 2'b00;
        endcase
        case (cls)
          C_JAL:   pc_sel = 2'b01;
          C_JALR:  pc_sel = 2'b10;
          default: pc_sel = 2'b00;
        endcase
      end

      S_HALT:  nxt = S_HALT;
      default: nxt = S_HALT;
    endcase

    // a reset cycle aborts whatever the current state was doing
    if (reset) begin
      imem_req = 1'b0;
      ir_we    = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      rf_we    = 1'b0;
      pc_we    = 1'b0;
      pc_sel   = 2'b00;
      wb_sel   = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur     <= S_FETCH;
      cls     <= C_NONE;
      wcnt    <= '0;
      instret <= '0;
      illegal <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      cur     <= nxt;
      cls     <= cls_nx;
      wcnt    <= wcnt_nx;
      illegal <= ill_nx;
      bus_err <= berr_nx;
      if (ret) instret <= instret + 32'd1;
    end
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255: the maximum number of wait cycles allowed for a memory handshake.
REQ-002 SHALL have ports:
- clk  in  1  sole clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- imem_ready  in  1  instruction memory has data on the current cycle
- opcode  in  7  instr[6:0] of the instruction register
- rd  in  5  instr[11:7]
- br_taken  in  1  ALU branch-compare result, valid in EXEC
- dmem_ready  in  1  data memory completes access on the current cycle
- imem_req  out  1  instruction fetch request
- ir_we  out  1  instruction register load strobe
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write enable (store)
- rf_we  out  1  register file write strobe
- pc_we  out  1  PC update strobe
- pc_sel  out  2  00 = pc+4, 01 = pc+imm (branch/JAL), 10 = rs1+imm (JALR)
- wb_sel  out  2  00 = ALU, 01 = load data, 10 = pc+4
- state  out  3  current FSM state encoding
- illegal  out  1  sticky; unsupported opcode seen
- bus_err  out  1  sticky; memory handshake timeout
- instret  out  32  count of retired instructions

Function
REQ-003 SHALL implement the states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; encodings 6-7 SHALL go to HALT on the next cycle.
REQ-004 In FETCH, imem_req SHALL be 1; on imem_ready=1, ir_we SHALL pulse for that cycle and the FSM SHALL move to DECODE.
REQ-005 DECODE SHALL last exactly 1 cycle and classify opcode into exactly one of these classes:
- R 0110011
- I-ALU 0010011
- LOAD 0000011
- STORE 0100011
- BRANCH 1100011
- JAL 1101111
- JALR 1100111
- LUI 0110111
- AUIPC 0010111
- FENCE 0001111
REQ-006 For any other opcode, including 1110011, DECODE SHALL set illegal=1 and enter HALT.
REQ-007 EXEC SHALL last exactly 1 cycle and transition by class:
- R / I-ALU / LUI / AUIPC / JAL / JALR -> WB
- LOAD / STORE -> MEM
- BRANCH -> FETCH, with pc_we=1, pc_sel=01 if br_taken else 00, and instret+1
- FENCE -> FETCH, with pc_we=1, pc_sel=00, and instret+1
REQ-008 In MEM, dmem_req SHALL be 1, and dmem_we SHALL be 1 only for STORE.
REQ-009 On dmem_ready=1 in MEM:
- STORE -> FETCH, with pc_we=1, pc_sel=00, and instret+1
- LOAD -> WB
REQ-010 WB SHALL last 1 cycle with rf_we=1 (forced 0 when rd==0), pc_we=1, instret+1, then enter FETCH.
REQ-011 In WB, wb_sel SHALL be 01 for LOAD, 10 for JAL/JALR, and 00 otherwise.
REQ-012 In WB, pc_sel SHALL be 01 for JAL, 10 for JALR, and 00 otherwise.
REQ-013 In every state other than WB, wb_sel SHALL be 00.
REQ-014 All strobes (ir_we, rf_we, pc_we, dmem_req, dmem_we, imem_req) SHALL be 0 except where this section asserts them.
REQ-015 The class SHALL be latched at DECODE and held until the next DECODE; opcode changes after DECODE SHALL have no effect.
REQ-016 The wait counter SHALL be cleared on entry to FETCH or MEM, and SHALL increment each cycle the request is high and ready is low.
REQ-017 When the wait counter equals MEM_TIMEOUT with ready still low, the block SHALL set bus_err=1 and enter HALT on the next edge.
REQ-018 A ready=1 on the same cycle the counter reaches MEM_TIMEOUT SHALL complete the access normally, with no error.
REQ-019 HALT SHALL deassert all strobes and hold until reset; illegal and bus_err SHALL persist in HALT.
REQ-020 instret SHALL wrap from 0xFFFFFFFF to 0 with no flag.
REQ-021 Outputs SHALL be Moore-style from the state and latched class, except that ir_we and the MEM-exit strobes SHALL be gated by the ready inputs.
REQ-022 Instruction latency SHALL be fixed at 1 fetch-wait cycle + 1 DECODE + 1 EXEC, plus:
- +1 (WB) for R/I/U/JAL/JALR
- +mem-wait+1 (MEM) for STORE
- +mem-wait+1 (MEM) +1 (WB) for LOAD
- +0 for BRANCH/FENCE

Reset
REQ-023 When reset=1 at a clock edge, the block SHALL set state=FETCH and clear the wait counter, instret, illegal, bus_err and the latched class.
REQ-024 All strobes SHALL be 0 during the reset cycle.
REQ-025 Reset asserted mid-operation, including in MEM with dmem_req high or in HALT, SHALL abort the instruction with no pc_we or rf_we in that cycle.
REQ-026 imem_req SHALL rise in the first cycle after reset deasserts.

Verification
REQ-027 ADD (0110011, rd=5) with imem_ready=1 immediately -> states 0,1,2,4,0; rf_we=1 and pc_we=1 only in WB; instret=1.
REQ-028 LW (rd=3) with dmem_ready delayed 3 cycles -> MEM lasts 4 cycles with dmem_req=1 and dmem_we=0; then WB with wb_sel=01; instret increments by 1.
REQ-029 Branch test: BEQ with br_taken=1 -> exit EXEC with pc_sel=01, pc_we=1 and no rf_we; repeat with br_taken=0 -> pc_sel=00.
REQ-030 Opcode 1110011 -> illegal=1 and state=5; no strobes for 10 cycles; a reset pulse returns state=0 with illegal=0.
REQ-031 MEM_TIMEOUT=4 with imem_ready held 0 -> bus_err=1 and HALT after 4 wait cycles; a repeat with ready=1 exactly on the 4th wait cycle -> normal DECODE.
REQ-032 ADDI with rd=0 -> rf_we stays 0 in WB while pc_we=1; reset asserted during a store's MEM -> no dmem_we on the following cycle and instret=0.
